// File: rtl/edge_acc_pkg.sv
// Shared widths, helpers and scan FSM encoding for the edge-mask accumulator.
package edge_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  // $clog2 that never collapses to a zero-width field.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : unsigned'($clog2(v));
  endfunction

  function automatic int unsigned calc_nw(input int unsigned tot, input int unsigned rw);
    return tot / rw;
  endfunction

  function automatic int unsigned calc_iw(input int unsigned tot);
    return clog2_min1(tot);
  endfunction

  function automatic int unsigned calc_cw(input int unsigned tot);
    return calc_iw(tot) + 1;
  endfunction

endpackage

// File: rtl/word_popcnt_ffs.sv
// Combinational popcount, lowest-set-bit index and nonzero flag for one word.
module word_popcnt_ffs
  import edge_acc_pkg::*;
#(
  parameter int unsigned RW = 32
) (
  input  logic [RW-1:0]                   word,
  output logic [clog2_min1(RW + 1)-1:0]   pop_c,
  output logic [clog2_min1(RW)-1:0]       low_c,
  output logic                            nz_c
);

  localparam int unsigned PW = clog2_min1(RW + 1);
  localparam int unsigned LW = clog2_min1(RW);

  // Walk downward so the last hit is the lowest set bit.
  always_comb begin
    pop_c = '0;
    low_c = '0;
    nz_c  = |word;
    for (int i = int'(RW) - 1; i >= 0; i--) begin
      pop_c = pop_c + PW'(word[i]);
      if (word[i]) low_c = LW'(i);
    end
  end

endmodule

// File: rtl/edge_acc_scan.sv
// Sticky OR accumulator of NCH edge masks with word readback and a
// one-word-per-cycle scan reporting set-bit count and lowest set index.
module edge_acc_scan
  import edge_acc_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned CHW = 512,
  parameter int unsigned RW  = 32
) (
  input  logic                                        CLK,
  input  logic                                        RST,
  input  logic [NCH*CHW-1:0]                          mask_in,
  input  logic                                        acc_en,
  input  logic                                        acc_clr,
  input  logic                                        rd_req,
  input  logic [clog2_min1(NCH)-1:0]                  rd_ch,
  input  logic [clog2_min1(CHW/RW)-1:0]               rd_word,
  output logic                                        rd_valid,
  output logic [RW-1:0]                               rd_data,
  input  logic                                        scan_start,
  output logic                                        scan_busy,
  output logic                                        scan_done,
  output logic [calc_cw(NCH*CHW)-1:0]                 scan_count,
  output logic [calc_iw(NCH*CHW)-1:0]                 scan_first,
  output logic                                        scan_any
);

  localparam int unsigned TOT = NCH * CHW;
  localparam int unsigned NW  = calc_nw(TOT, RW);
  localparam int unsigned IW  = calc_iw(TOT);
  localparam int unsigned CW  = calc_cw(TOT);
  localparam int unsigned WPC = CHW / RW;
  localparam int unsigned WPW = clog2_min1(NW);
  localparam int unsigned LW  = clog2_min1(RW);
  localparam int unsigned PW  = clog2_min1(RW + 1);

  logic [NW-1:0][RW-1:0] acc;
  logic [RW-1:0]         rd_word_c;
  logic [WPW-1:0]        rd_idx_c;

  scan_state_e    state;
  logic [WPW-1:0] wp;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  first;
  logic           found;

  logic [RW-1:0]  scan_word_c;
  logic [PW-1:0]  pop_c;
  logic [LW-1:0]  low_c;
  logic           nz_c;
  logic [CW-1:0]  cnt_next_c;
  logic [IW-1:0]  first_new_c;
  logic           take_first_c;

  // Clear has priority over accumulate.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (acc_en) begin
      acc <= acc | mask_in;
    end
  end

  assign rd_idx_c = WPW'(32'(rd_ch) * WPC + 32'(rd_word));

  always_comb begin
    rd_word_c = '0;
    if (32'(rd_ch) < NCH) rd_word_c = acc[rd_idx_c];
  end

  // Readback reflects the accumulator as it stood before the request edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= rd_word_c;
    end
  end

  assign scan_word_c = acc[wp];

  word_popcnt_ffs #(.RW(RW)) u_scan_word (
    .word  (scan_word_c),
    .pop_c (pop_c),
    .low_c (low_c),
    .nz_c  (nz_c)
  );

  assign cnt_next_c   = cnt + CW'(pop_c);
  assign first_new_c  = IW'({wp, low_c});
  assign take_first_c = !found && nz_c;

  // Scan engine; final word's contribution is folded straight into the outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      wp         <= '0;
      cnt        <= '0;
      first      <= '0;
      found      <= 1'b0;
      scan_busy  <= 1'b0;
      scan_done  <= 1'b0;
      scan_count <= '0;
      scan_first <= '0;
      scan_any   <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          if (scan_start) begin
            state     <= SCAN;
            scan_busy <= 1'b1;
            wp        <= '0;
            cnt       <= '0;
            first     <= '0;
            found     <= 1'b0;
          end
        end
        SCAN: begin
          cnt <= cnt_next_c;
          wp  <= wp + WPW'(1);
          if (take_first_c) begin
            found <= 1'b1;
            first <= first_new_c;
          end
          if (wp == WPW'(NW - 1)) begin
            state      <= DONE;
            scan_busy  <= 1'b0;
            scan_done  <= 1'b1;
            scan_count <= cnt_next_c;
            scan_first <= take_first_c ? first_new_c : first;
            scan_any   <= found | nz_c;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_edge_acc_scan.sv
// Directed bench for edge_acc_scan: reset, sticky accumulate, readback timing,
// clear priority, scan results, mid-scan updates and reset abort.
module tb_edge_acc_scan;

  localparam int unsigned NCH = 4;
  localparam int unsigned CHW = 512;
  localparam int unsigned RW  = 32;
  localparam int unsigned TOT = NCH * CHW;
  localparam int unsigned IW  = 11;
  localparam int unsigned CW  = 12;

  logic            CLK = 1'b0;
  logic            RST;
  logic [TOT-1:0]  mask_in;
  logic            acc_en;
  logic            acc_clr;
  logic            rd_req;
  logic [1:0]      rd_ch;
  logic [3:0]      rd_word;
  logic            rd_valid;
  logic [RW-1:0]   rd_data;
  logic            scan_start;
  logic            scan_busy;
  logic            scan_done;
  logic [CW-1:0]   scan_count;
  logic [IW-1:0]   scan_first;
  logic            scan_any;

  int vectors = 0;
  int miscompares = 0;

  edge_acc_scan #(.NCH(NCH), .CHW(CHW), .RW(RW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .mask_in    (mask_in),
    .acc_en     (acc_en),
    .acc_clr    (acc_clr),
    .rd_req     (rd_req),
    .rd_ch      (rd_ch),
    .rd_word    (rd_word),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .scan_start (scan_start),
    .scan_busy  (scan_busy),
    .scan_done  (scan_done),
    .scan_count (scan_count),
    .scan_first (scan_first),
    .scan_any   (scan_any)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Runs one scan for a bounded window, optionally pulsing scan_start again
  // and injecting an accumulate at chosen cycle offsets.
  task automatic run_scan(input int spulse, input int inj_at, input logic [TOT-1:0] inj,
                          output int busy_n, output int done_n, output int done_at,
                          output logic [CW-1:0] c, output logic [IW-1:0] f, output logic a);
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1; c = '0; f = '0; a = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (scan_busy) busy_n++;
      if (scan_done) begin
        done_n++;
        done_at = i;
        c = scan_count;
        f = scan_first;
        a = scan_any;
      end
      scan_start = (i == spulse);
      acc_en     = (i == inj_at);
      mask_in    = (i == inj_at) ? inj : '0;
      step();
    end
    scan_start = 1'b0;
    acc_en     = 1'b0;
    mask_in    = '0;
  endtask

  task automatic test_reset();
    RST = 1'b1; acc_en = 1'b1; mask_in = '1; acc_clr = 1'b0;
    rd_req = 1'b0; rd_ch = '0; rd_word = '0; scan_start = 1'b0;
    step(); step();
    vectors++; if (scan_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", scan_busy); end
    vectors++; if (scan_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b expected 0", scan_done); end
    vectors++; if (scan_count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", scan_count); end
    vectors++; if (scan_first !== '0) begin miscompares++; $display("FAIL reset_first: got %0d expected 0", scan_first); end
    vectors++; if (scan_any !== 1'b0) begin miscompares++; $display("FAIL reset_any: got %0b expected 0", scan_any); end
    vectors++; if (rd_valid !== 1'b0 || rd_data !== '0) begin miscompares++; $display("FAIL reset_rd: got valid %0b data %0h expected 0 0", rd_valid, rd_data); end
    RST = 1'b0; acc_en = 1'b0; mask_in = '0;
    rd_req = 1'b1; rd_ch = 2'd0; rd_word = 4'd0;
    step();
    rd_req = 1'b0;
    vectors++; if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin miscompares++; $display("FAIL reset_read: got valid %0b data %0h expected 1 0", rd_valid, rd_data); end
    step();
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL idle_valid: got %0b expected 0", rd_valid); end
  endtask

  task automatic test_sticky();
    acc_en = 1'b1; mask_in = '0; mask_in[5] = 1'b1;
    step();
    mask_in = '0; mask_in[37] = 1'b1;
    step();
    acc_en = 1'b0; mask_in = '0;
    step();
    for (int pass = 0; pass < 2; pass++) begin
      rd_req = 1'b1; rd_ch = 2'd0; rd_word = 4'd0;
      step();
      vectors++; if (rd_valid !== 1'b1 || rd_data !== 32'h20) begin miscompares++; $display("FAIL sticky_w0: got valid %0b data %0h expected 1 20", rd_valid, rd_data); end
      rd_word = 4'd1;
      step();
      vectors++; if (rd_valid !== 1'b1 || rd_data !== 32'h20) begin miscompares++; $display("FAIL sticky_w1: got valid %0b data %0h expected 1 20", rd_valid, rd_data); end
      rd_req = 1'b0;
      step();
    end
  endtask

  task automatic test_read_timing();
    rd_req = 1'b1; rd_ch = 2'd0; rd_word = 4'd2;
    acc_en = 1'b1; mask_in = '0; mask_in[64] = 1'b1;
    step();
    acc_en = 1'b0; mask_in = '0;
    vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL read_pre_update: got %0h expected 0", rd_data); end
    step();
    vectors++; if (rd_data !== 32'h1) begin miscompares++; $display("FAIL read_post_update: got %0h expected 1", rd_data); end
    rd_word = 4'd0;
    step();
    vectors++; if (rd_valid !== 1'b1 || rd_data !== 32'h20) begin miscompares++; $display("FAIL b2b_w0: got %0b %0h expected 1 20", rd_valid, rd_data); end
    rd_req = 1'b0;
    acc_en = 1'b1; mask_in = '0; mask_in[CHW + 3] = 1'b1; mask_in[TOT - 1] = 1'b1;
    step();
    acc_en = 1'b0; mask_in = '0;
    vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drop: got %0b expected 0", rd_valid); end
    rd_req = 1'b1; rd_ch = 2'd1; rd_word = 4'd0;
    step();
    vectors++; if (rd_data !== 32'h8) begin miscompares++; $display("FAIL ch1_w0: got %0h expected 8", rd_data); end
    rd_ch = 2'd3; rd_word = 4'd15;
    step();
    rd_req = 1'b0;
    vectors++; if (rd_data !== 32'h8000_0000) begin miscompares++; $display("FAIL ch3_w15: got %0h expected 80000000", rd_data); end
  endtask

  task automatic test_clear();
    acc_clr = 1'b1; acc_en = 1'b1; mask_in = '1;
    step();
    acc_clr = 1'b0; acc_en = 1'b0; mask_in = '0;
    for (int ch = 0; ch < 4; ch++) begin
      for (int w = 0; w < 16; w++) begin
        rd_req = 1'b1; rd_ch = 2'(ch); rd_word = 4'(w);
        step();
        vectors++;
        if (rd_valid !== 1'b1 || rd_data !== 32'h0) begin
          miscompares++;
          $display("FAIL clear_ch%0d_w%0d: got valid %0b data %0h expected 1 0", ch, w, rd_valid, rd_data);
        end
      end
    end
    rd_req = 1'b0;
    step();
  endtask

  task automatic test_scan_basic();
    int bn, dn, da;
    logic [CW-1:0] c;
    logic [IW-1:0] f;
    logic a;
    acc_en = 1'b1; mask_in = '0;
    mask_in[100] = 1'b1; mask_in[1600] = 1'b1; mask_in[2047] = 1'b1;
    step();
    acc_en = 1'b0; mask_in = '0;
    run_scan(-1, -1, '0, bn, dn, da, c, f, a);
    vectors++; if (bn != 64) begin miscompares++; $display("FAIL scan_busy_len: got %0d expected 64", bn); end
    vectors++; if (dn != 1 || da != 64) begin miscompares++; $display("FAIL scan_done_pulse: got %0d at %0d expected 1 at 64", dn, da); end
    vectors++; if (c !== 12'd3 || f !== 11'd100 || a !== 1'b1) begin miscompares++; $display("FAIL scan_result: got %0d/%0d/%0b expected 3/100/1", c, f, a); end
    vectors++; if (scan_count !== 12'd3 || scan_first !== 11'd100) begin miscompares++; $display("FAIL scan_hold: got %0d/%0d expected 3/100", scan_count, scan_first); end
  endtask

  task automatic test_scan_empty();
    int bn, dn, da;
    logic [CW-1:0] c;
    logic [IW-1:0] f;
    logic a;
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    run_scan(10, -1, '0, bn, dn, da, c, f, a);
    vectors++; if (bn != 64) begin miscompares++; $display("FAIL empty_busy_len: got %0d expected 64", bn); end
    vectors++; if (dn != 1 || da != 64) begin miscompares++; $display("FAIL empty_single_done: got %0d at %0d expected 1 at 64", dn, da); end
    vectors++; if (c !== 12'd0 || f !== 11'd0 || a !== 1'b0) begin miscompares++; $display("FAIL empty_result: got %0d/%0d/%0b expected 0/0/0", c, f, a); end
  endtask

  task automatic test_scan_live_update();
    int bn, dn, da;
    logic [CW-1:0] c;
    logic [IW-1:0] f;
    logic a;
    logic [TOT-1:0] inj;
    inj = '0; inj[0] = 1'b1; inj[2047] = 1'b1;
    run_scan(-1, 3, inj, bn, dn, da, c, f, a);
    vectors++; if (dn != 1) begin miscompares++; $display("FAIL live_done: got %0d expected 1", dn); end
    vectors++; if (c !== 12'd1 || f !== 11'd2047 || a !== 1'b1) begin miscompares++; $display("FAIL live_result: got %0d/%0d/%0b expected 1/2047/1", c, f, a); end
  endtask

  task automatic test_reset_abort();
    int dn;
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    acc_en = 1'b1; mask_in = '0; mask_in[300] = 1'b1;
    step();
    acc_en = 1'b0; mask_in = '0;
    scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    for (int i = 0; i < 20; i++) step();
    vectors++; if (scan_busy !== 1'b1) begin miscompares++; $display("FAIL abort_pre_busy: got %0b expected 1", scan_busy); end
    RST = 1'b1;
    step();
    RST = 1'b0;
    vectors++; if (scan_busy !== 1'b0 || scan_done !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got busy %0b done %0b expected 0 0", scan_busy, scan_done); end
    vectors++; if (scan_count !== '0 || scan_first !== '0 || scan_any !== 1'b0) begin miscompares++; $display("FAIL abort_outputs: got %0d/%0d/%0b expected 0/0/0", scan_count, scan_first, scan_any); end
    dn = 0;
    for (int i = 0; i < 80; i++) begin
      if (scan_done || scan_busy) dn++;
      step();
    end
    vectors++; if (dn != 0) begin miscompares++; $display("FAIL abort_no_done: got %0d active cycles expected 0", dn); end
    rd_req = 1'b1; rd_ch = 2'd0; rd_word = 4'd9;
    step();
    rd_req = 1'b0;
    vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL abort_acc_cleared: got %0h expected 0", rd_data); end
  endtask

  initial begin
    test_reset();
    test_sticky();
    test_read_timing();
    test_clear();
    test_scan_basic();
    test_scan_empty();
    test_scan_live_update();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
